// File: rtl/alien_pkg.sv
// Shared types and default geometry for the alien formation movement engine.
package alien_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RIGHT  = 3'd1,
        ST_DROP_L = 3'd2,
        ST_LEFT   = 3'd3,
        ST_DROP_R = 3'd4,
        ST_LANDED = 3'd5
    } alien_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned DEF_X_W     = $clog2(SCREEN_W);
    localparam int unsigned DEF_Y_W     = $clog2(SCREEN_H);
    localparam int unsigned DEF_X_MIN   = 34;
    localparam int unsigned DEF_X_MAX   = 42;
    localparam int unsigned DEF_X_START = 34;
    localparam int unsigned DEF_Y_START = 15;
    localparam int unsigned DEF_DROP    = 4;
    localparam int unsigned DEF_Y_LIMIT = 111;

endpackage

// File: rtl/alien_mover_step_timer.sv
// Tick divider plus frame counter; pulses step once per reloadable period of ticks.
module step_timer #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned PER_W    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clear,
    input  logic [PER_W-1:0] period,
    output logic             step
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]    tick_q;
    logic [PER_W-1:0] frame_q;
    logic             tick_last_c;
    logic             frame_last_c;

    assign tick_last_c  = (tick_q == TW'(TICK_DIV - 1));
    assign frame_last_c = (frame_q == (period - PER_W'(1)));
    assign step         = en & tick_last_c & frame_last_c;

    // Counters advance only while enabled; clear wins over counting.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else if (en) begin
            tick_q <= tick_last_c ? '0 : tick_q + TW'(1);
            if (tick_last_c) begin
                frame_q <= frame_last_c ? '0 : frame_q + PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/alien_mover.sv
// Sweeps one alien formation between x bounds, dropping and speeding up at each edge.
module alien_mover
    import alien_pkg::*;
#(
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned X_START     = DEF_X_START,
    parameter int unsigned Y_START     = DEF_Y_START,
    parameter int unsigned X_MIN       = DEF_X_MIN,
    parameter int unsigned X_MAX       = DEF_X_MAX,
    parameter int unsigned DROP        = DEF_DROP,
    parameter int unsigned Y_LIMIT     = DEF_Y_LIMIT,
    parameter int unsigned TICK_DIV    = 833333,
    parameter int unsigned FRAMES_INIT = 15,
    parameter int unsigned FRAMES_MIN  = 2,
    parameter int unsigned SPEEDUP     = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic           pause,
    input  logic           halt,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           dir,
    output logic           moving,
    output logic           landed
);

    localparam int unsigned PER_W = $clog2(FRAMES_INIT + 1);

    alien_state_t     state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             dir_q, dir_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             moving_q, moving_d;
    logic             landed_q, landed_d;
    logic             clear_c;
    logic             en_c;
    logic             step_c;
    logic [Y_W:0]     y_sum_c;

    assign x      = x_q;
    assign y      = y_q;
    assign dir    = dir_q;
    assign moving = moving_q;
    assign landed = landed_q;

    // One bit wider than y so the drop sum cannot wrap past the floor check.
    assign y_sum_c = {1'b0, y_q} + (Y_W + 1)'(DROP);
    assign en_c    = ((state_q == ST_RIGHT) || (state_q == ST_LEFT)) && !pause;

    step_timer #(
        .TICK_DIV (TICK_DIV),
        .PER_W    (PER_W)
    ) u_step_timer (
        .clk    (clk),
        .resetn (resetn),
        .en     (en_c),
        .clear  (clear_c),
        .period (period_q),
        .step   (step_c)
    );

    // State, position and status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            x_q      <= X_W'(X_START);
            y_q      <= Y_W'(Y_START);
            dir_q    <= DIR_RIGHT;
            period_q <= PER_W'(FRAMES_INIT);
            moving_q <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            moving_q <= moving_d;
            landed_q <= landed_d;
        end
    end

    // Next-state, position update and registered status decode.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        period_d = period_q;
        clear_c  = 1'b0;

        if (halt) begin
            state_d = ST_IDLE;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_LANDED: begin
                    if (go) begin
                        x_d      = X_W'(X_START);
                        y_d      = Y_W'(Y_START);
                        period_d = PER_W'(FRAMES_INIT);
                        dir_d    = DIR_RIGHT;
                        clear_c  = 1'b1;
                        state_d  = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (step_c) begin
                        if (x_q == X_W'(X_MAX)) begin
                            state_d = ST_DROP_L;
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end
                end
                ST_LEFT: begin
                    if (step_c) begin
                        if (x_q == X_W'(X_MIN)) begin
                            state_d = ST_DROP_R;
                        end else begin
                            x_d = x_q - X_W'(1);
                        end
                    end
                end
                ST_DROP_L, ST_DROP_R: begin
                    clear_c = 1'b1;
                    if (y_sum_c > (Y_W + 1)'(Y_LIMIT)) begin
                        state_d = ST_LANDED;
                    end else begin
                        y_d = y_sum_c[Y_W-1:0];
                        if (32'(period_q) >= (FRAMES_MIN + SPEEDUP)) begin
                            period_d = period_q - PER_W'(SPEEDUP);
                        end else begin
                            period_d = PER_W'(FRAMES_MIN);
                        end
                        dir_d   = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                        state_d = (state_q == ST_DROP_L) ? ST_LEFT : ST_RIGHT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        moving_d = (state_d == ST_RIGHT) || (state_d == ST_LEFT) ||
                   (state_d == ST_DROP_L) || (state_d == ST_DROP_R);
        landed_d = (state_d == ST_LANDED);
    end

endmodule
